serial_bus_scheduler: RTL and testbench

Two-master, three-slave scheduler for the bit-serial shared bus. It grants the bus round-robin, shifts in the master's serial address, and decodes the slave from the top address bits. It replays the local address to the selected slave, forwards write data or returns read data, and enforces a slave-response timeout. It sits between the master instances and the slave instances, clocked by the divided bus tick.

---
 rtl/serial_bus_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_serial_bus_scheduler.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_scheduler.sv
// -----------------------------------------------------------------------------
// serial_bus_scheduler
//
// Schedules a bit-serial shared bus between two masters and three slaves.
// A granted master shifts in a serial address (MSB first). The two top bits
// pick the slave (00->s1, 01->s2, 10->s3, 11->error). The scheduler then
// replays the remaining local address bits to that slave. After that it
// either forwards write data and waits for the slave ack, or returns the
// slave's read data to the master. A per-bit timeout guards slave responses.
// Arbitration is round-robin between the two masters.
//
// Ports
//   clk, reset                     divided bus tick; asynchronous active-high clear
//   mX_request                     bus request, held for the whole transaction
//   mX_wr                          1 = write, 0 = read (taken on the grant edge)
//   mX_address / mX_address_valid  serial address bit and qualifier
//   mX_data / mX_valid             serial write-data bit and qualifier
//   mX_available                   grant, high from grant through DONE
//   mX_data_out / mX_ready         serial read-data bit and qualifier
//   mX_done / mX_error             one-cycle completion pulse / error flag
//   sX_address, sX_data, sX_valid  slave-side serial address, write data, qualifier
//   sX_wr                          write level for the selected slave
//   sX_data_in / sX_ready          slave read bit and qualifier (ack for writes)
// -----------------------------------------------------------------------------
module serial_bus_scheduler #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  // master 1
  input  logic m1_request,
  input  logic m1_wr,
  input  logic m1_address,
  input  logic m1_address_valid,
  input  logic m1_data,
  input  logic m1_valid,
  output logic m1_available,
  output logic m1_data_out,
  output logic m1_ready,
  output logic m1_done,
  output logic m1_error,
  // master 2
  input  logic m2_request,
  input  logic m2_wr,
  input  logic m2_address,
  input  logic m2_address_valid,
  input  logic m2_data,
  input  logic m2_valid,
  output logic m2_available,
  output logic m2_data_out,
  output logic m2_ready,
  output logic m2_done,
  output logic m2_error,
  // slave 1
  output logic s1_address,
  output logic s1_data,
  output logic s1_valid,
  output logic s1_wr,
  input  logic s1_data_in,
  input  logic s1_ready,
  // slave 2
  output logic s2_address,
  output logic s2_data,
  output logic s2_valid,
  output logic s2_wr,
  input  logic s2_data_in,
  input  logic s2_ready,
  // slave 3
  output logic s3_address,
  output logic s3_data,
  output logic s3_valid,
  output logic s3_wr,
  input  logic s3_data_in,
  input  logic s3_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_AOUT  = 3'd2,
    ST_WDATA = 3'd3,
    ST_WACK  = 3'd4,
    ST_RDATA = 3'd5,
    ST_ERR   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  // AOUT emits its first bit on entry, so it counts one fewer step.
  localparam logic [CNT_W-1:0] AOUT_LAST = CNT_W'(ADDR_W - 3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Map the slave-select field to a one-hot slave vector; 11 means no slave.
  function automatic logic [2:0] decode_slave(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      2'b00:   oh = 3'b001;
      2'b01:   oh = 3'b010;
      2'b10:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin pick: on a tie the master not granted last wins.
  function automatic logic [1:0] pick_master(input logic [1:0] req, input logic last_m2);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_m2 ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // state and control registers
  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;      // one-hot granted master
  logic                last_m2_q, last_m2_d;  // 1 = m2 was granted last
  logic                wr_q, wr_d;
  logic [ADDR_W-2:0]   addr_sr_q, addr_sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [2:0]          slave_q, slave_d;      // one-hot selected slave

  // output registers
  logic [1:0] m_avail_q, m_avail_d;
  logic [1:0] m_dout_q, m_dout_d;
  logic [1:0] m_rdy_q, m_rdy_d;
  logic [1:0] m_done_q, m_done_d;
  logic [1:0] m_err_q, m_err_d;
  logic [2:0] s_addr_q, s_addr_d;
  logic [2:0] s_data_q, s_data_d;
  logic [2:0] s_valid_q, s_valid_d;
  logic [2:0] s_wr_q, s_wr_d;

  // gathered inputs and selected-lane views
  logic [1:0]        m_req_s, m_wr_s, m_addr_s, m_aval_s, m_data_s, m_valid_s;
  logic [2:0]        s_din_s, s_rdy_s;
  logic              req_sel_s, addr_sel_s, aval_sel_s, data_sel_s, valid_sel_s;
  logic              sdin_sel_s, srdy_sel_s;
  logic [ADDR_W-1:0] full_addr_s;
  logic [2:0]        slave_dec_s;
  logic              abort_s;

  assign m_req_s   = {m2_request, m1_request};
  assign m_wr_s    = {m2_wr, m1_wr};
  assign m_addr_s  = {m2_address, m1_address};
  assign m_aval_s  = {m2_address_valid, m1_address_valid};
  assign m_data_s  = {m2_data, m1_data};
  assign m_valid_s = {m2_valid, m1_valid};
  assign s_din_s   = {s3_data_in, s2_data_in, s1_data_in};
  assign s_rdy_s   = {s3_ready, s2_ready, s1_ready};

  assign req_sel_s   = |(m_req_s & grant_q);
  assign addr_sel_s  = |(m_addr_s & grant_q);
  assign aval_sel_s  = |(m_aval_s & grant_q);
  assign data_sel_s  = |(m_data_s & grant_q);
  assign valid_sel_s = |(m_valid_s & grant_q);
  assign sdin_sel_s  = |(s_din_s & slave_q);
  assign srdy_sel_s  = |(s_rdy_s & slave_q);

  // Address as it will look once the bit being sampled now is shifted in.
  assign full_addr_s = {addr_sr_q, addr_sel_s};
  assign slave_dec_s = decode_slave(full_addr_s[ADDR_W-1:ADDR_W-2]);

  // Losing the request mid-transaction abandons it without a done pulse.
  assign abort_s = (state_q != ST_IDLE) && (state_q != ST_DONE) && !req_sel_s;

  // Register all state and outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      last_m2_q <= 1'b1;
      wr_q      <= 1'b0;
      addr_sr_q <= {(ADDR_W-1){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      tmo_q     <= 8'd0;
      slave_q   <= 3'b000;
      m_avail_q <= 2'b00;
      m_dout_q  <= 2'b00;
      m_rdy_q   <= 2'b00;
      m_done_q  <= 2'b00;
      m_err_q   <= 2'b00;
      s_addr_q  <= 3'b000;
      s_data_q  <= 3'b000;
      s_valid_q <= 3'b000;
      s_wr_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_m2_q <= last_m2_d;
      wr_q      <= wr_d;
      addr_sr_q <= addr_sr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      slave_q   <= slave_d;
      m_avail_q <= m_avail_d;
      m_dout_q  <= m_dout_d;
      m_rdy_q   <= m_rdy_d;
      m_done_q  <= m_done_d;
      m_err_q   <= m_err_d;
      s_addr_q  <= s_addr_d;
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
      s_wr_q    <= s_wr_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_m2_d = last_m2_q;
    wr_d      = wr_q;
    addr_sr_d = addr_sr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    slave_d   = slave_q;
    m_avail_d = m_avail_q;
    m_dout_d  = 2'b00;
    m_rdy_d   = 2'b00;
    m_done_d  = 2'b00;
    m_err_d   = 2'b00;
    s_addr_d  = 3'b000;
    s_data_d  = 3'b000;
    s_valid_d = 3'b000;
    s_wr_d    = s_wr_q;

    if (abort_s) begin
      // Pointer still advances so the other master gets the next tie.
      state_d   = ST_IDLE;
      grant_d   = 2'b00;
      m_avail_d = 2'b00;
      last_m2_d = grant_q[1];
      slave_d   = 3'b000;
      s_wr_d    = 3'b000;
      cnt_d     = {CNT_W{1'b0}};
      tmo_d     = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|m_req_s) begin
            grant_d   = pick_master(m_req_s, last_m2_q);
            m_avail_d = grant_d;
            wr_d      = |(m_wr_s & grant_d);
            addr_sr_d = {(ADDR_W-1){1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            state_d   = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ADDR: begin
          if (aval_sel_s) begin
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = {CNT_W{1'b0}};
              slave_d = slave_dec_s;
              if (slave_dec_s == 3'b000) begin
                addr_sr_d = full_addr_s[ADDR_W-2:0];
                state_d   = ST_ERR;
              end else begin
                // First local bit goes out now; the rest are pre-shifted so
                // addr_sr_q[ADDR_W-3] always holds the next bit to send.
                addr_sr_d = {full_addr_s[ADDR_W-3:0], 1'b0};
                s_addr_d  = slave_dec_s & {3{full_addr_s[ADDR_W-3]}};
                s_valid_d = slave_dec_s;
                s_wr_d    = slave_dec_s & {3{wr_q}};
                state_d   = ST_AOUT;
              end
            end else begin
              addr_sr_d = full_addr_s[ADDR_W-2:0];
              cnt_d     = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_AOUT: begin
          if (cnt_q == AOUT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            tmo_d   = 8'd0;
            state_d = wr_q ? ST_WDATA : ST_RDATA;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
            s_addr_d  = slave_q & {3{addr_sr_q[ADDR_W-3]}};
            s_valid_d = slave_q;
            addr_sr_d = {addr_sr_q[ADDR_W-3:0], 1'b0};
          end
        end

        ST_WDATA: begin
          s_data_d  = slave_q & {3{data_sel_s}};
          s_valid_d = slave_q & {3{valid_sel_s}};
          if (valid_sel_s) begin
            if (cnt_q == DATA_LAST) begin
              cnt_d   = {CNT_W{1'b0}};
              tmo_d   = 8'd0;
              state_d = ST_WACK;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end

        ST_WACK: begin
          if (srdy_sel_s) begin
            m_done_d = grant_q;
            s_wr_d   = 3'b000;
            state_d  = ST_DONE;
          end else if (tmo_q == TMO_LAST) begin
            m_done_d = grant_q;
            m_err_d  = grant_q;
            s_wr_d   = 3'b000;
            state_d  = ST_DONE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end

        ST_RDATA: begin
          m_dout_d = grant_q & {2{sdin_sel_s}};
          m_rdy_d  = grant_q & {2{srdy_sel_s}};
          if (srdy_sel_s) begin
            tmo_d = 8'd0;
            if (cnt_q == DATA_LAST) begin
              cnt_d    = {CNT_W{1'b0}};
              m_done_d = grant_q;
              s_wr_d   = 3'b000;
              state_d  = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            m_done_d = grant_q;
            m_err_d  = grant_q;
            s_wr_d   = 3'b000;
            state_d  = ST_DONE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end

        ST_ERR: begin
          m_done_d = grant_q;
          m_err_d  = grant_q;
          state_d  = ST_DONE;
        end

        ST_DONE: begin
          state_d   = ST_IDLE;
          grant_d   = 2'b00;
          m_avail_d = 2'b00;
          last_m2_d = grant_q[1];
          slave_d   = 3'b000;
          s_wr_d    = 3'b000;
        end

        default: begin
          state_d   = ST_IDLE;
          grant_d   = 2'b00;
          m_avail_d = 2'b00;
          slave_d   = 3'b000;
          s_wr_d    = 3'b000;
        end
      endcase
    end
  end

  assign m1_available = m_avail_q[0];
  assign m2_available = m_avail_q[1];
  assign m1_data_out  = m_dout_q[0];
  assign m2_data_out  = m_dout_q[1];
  assign m1_ready     = m_rdy_q[0];
  assign m2_ready     = m_rdy_q[1];
  assign m1_done      = m_done_q[0];
  assign m2_done      = m_done_q[1];
  assign m1_error     = m_err_q[0];
  assign m2_error     = m_err_q[1];

  assign s1_address = s_addr_q[0];
  assign s2_address = s_addr_q[1];
  assign s3_address = s_addr_q[2];
  assign s1_data    = s_data_q[0];
  assign s2_data    = s_data_q[1];
  assign s3_data    = s_data_q[2];
  assign s1_valid   = s_valid_q[0];
  assign s2_valid   = s_valid_q[1];
  assign s3_valid   = s_valid_q[2];
  assign s1_wr      = s_wr_q[0];
  assign s2_wr      = s_wr_q[1];
  assign s3_wr      = s_wr_q[2];

endmodule

// File: tb/tb_serial_bus_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for serial_bus_scheduler. Inputs are driven and outputs sampled on
// the falling clock edge. Expected slave index, local address, data words and
// completion status are derived from the transaction parameters alone.
// -----------------------------------------------------------------------------
module tb_serial_bus_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] req, wr, maddr, maval, mdata, mval;
  logic [2:0] sdin, srdy;
  logic [1:0] avail, dout, mrdy, done, err;
  logic [2:0] saddr, sdata, svalid, swr;

  int checks = 0;
  int failures = 0;

  // observation accumulators (written only by tick/clear_obs)
  int          cyc;
  int          s_vcnt [3];
  logic [11:0] cap_addr [3];
  logic [7:0]  cap_data [3];
  bit          wr_seen [3];
  int          rd_cnt [2];
  logic [7:0]  rd_word [2];
  int          done_cnt [2];
  int          err_cnt [2];
  int          done_cyc [2];
  int          stray;

  always #5 clk = ~clk;

  serial_bus_scheduler dut (
    .clk(clk), .reset(reset),
    .m1_request(req[0]), .m1_wr(wr[0]), .m1_address(maddr[0]), .m1_address_valid(maval[0]),
    .m1_data(mdata[0]), .m1_valid(mval[0]), .m1_available(avail[0]), .m1_data_out(dout[0]),
    .m1_ready(mrdy[0]), .m1_done(done[0]), .m1_error(err[0]),
    .m2_request(req[1]), .m2_wr(wr[1]), .m2_address(maddr[1]), .m2_address_valid(maval[1]),
    .m2_data(mdata[1]), .m2_valid(mval[1]), .m2_available(avail[1]), .m2_data_out(dout[1]),
    .m2_ready(mrdy[1]), .m2_done(done[1]), .m2_error(err[1]),
    .s1_address(saddr[0]), .s1_data(sdata[0]), .s1_valid(svalid[0]), .s1_wr(swr[0]),
    .s1_data_in(sdin[0]), .s1_ready(srdy[0]),
    .s2_address(saddr[1]), .s2_data(sdata[1]), .s2_valid(svalid[1]), .s2_wr(swr[1]),
    .s2_data_in(sdin[1]), .s2_ready(srdy[1]),
    .s3_address(saddr[2]), .s3_data(sdata[2]), .s3_valid(svalid[2]), .s3_wr(swr[2]),
    .s3_data_in(sdin[2]), .s3_ready(srdy[2])
  );

  function automatic logic [21:0] all_outs();
    return {avail, dout, mrdy, done, err, saddr, sdata, svalid, swr};
  endfunction

  task automatic zero_inputs();
    req = 2'b00; wr = 2'b00; maddr = 2'b00; maval = 2'b00; mdata = 2'b00; mval = 2'b00;
    sdin = 3'b000; srdy = 3'b000;
  endtask

  task automatic clear_obs();
    for (int s = 0; s < 3; s++) begin
      s_vcnt[s] = 0; cap_addr[s] = 12'h000; cap_data[s] = 8'h00; wr_seen[s] = 1'b0;
    end
    for (int m = 0; m < 2; m++) begin
      rd_cnt[m] = 0; rd_word[m] = 8'h00; done_cnt[m] = 0; err_cnt[m] = 0; done_cyc[m] = 0;
    end
    stray = 0;
  endtask

  // Advance one cycle and record everything visible on the bus.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int s = 0; s < 3; s++) begin
      if (svalid[s]) begin
        if (s_vcnt[s] < 12) cap_addr[s] = {cap_addr[s][10:0], saddr[s]};
        else cap_data[s] = {cap_data[s][6:0], sdata[s]};
        s_vcnt[s]++;
      end
      if (swr[s]) wr_seen[s] = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      if (mrdy[m]) begin
        rd_word[m] = {rd_word[m][6:0], dout[m]};
        rd_cnt[m]++;
      end
      if (done[m]) begin
        done_cnt[m]++;
        done_cyc[m] = cyc;
      end
      if (err[m]) err_cnt[m]++;
      if (!avail[m] && (dout[m] || mrdy[m])) stray++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    zero_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_req(input int m, input logic w, output int n);
    req[m] = 1'b1;
    wr[m] = w;
    n = 9;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (avail[m]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic send_addr(input int m, input logic [13:0] a, input bit gapless);
    for (int i = 13; i >= 0; i--) begin
      if (!gapless) repeat ($urandom_range(2, 0)) tick();
      maddr[m] = a[i];
      maval[m] = 1'b1;
      tick();
      maval[m] = 1'b0;
      maddr[m] = 1'b0;
    end
  endtask

  task automatic wait_aout_end(input int s);
    for (int k = 0; k < 40; k++) begin
      if (s_vcnt[s] >= 12 && !svalid[s]) break;
      tick();
    end
  endtask

  task automatic wait_done(input int m, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (done_cnt[m] > 0) break;
      tick();
    end
  endtask

  task automatic run_write(input int m, input logic [13:0] a, input logic [7:0] d, input bit gapless);
    int s; int n; int others;
    s = int'(a[13:12]);
    clear_obs();
    start_req(m, 1'b1, n);
    checks++;
    if (n !== 1) begin failures++; $display("FAIL wr_grant_latency: got %0d expected 1", n); end
    send_addr(m, a, gapless);
    wait_aout_end(s);
    for (int i = 7; i >= 0; i--) begin
      if (!gapless) repeat ($urandom_range(2, 0)) tick();
      mdata[m] = d[i];
      mval[m] = 1'b1;
      tick();
      mval[m] = 1'b0;
      mdata[m] = 1'b0;
    end
    repeat ($urandom_range(4, 0)) tick();
    checks++;
    if (done_cnt[m] !== 0) begin failures++; $display("FAIL wr_done_before_ack: got %0d expected 0", done_cnt[m]); end
    srdy[s] = 1'b1;
    tick();
    srdy[s] = 1'b0;
    wait_done(m, 4);
    req[m] = 1'b0;
    tick();
    tick();
    others = 0;
    for (int k = 0; k < 3; k++) if (k != s) others += s_vcnt[k];
    checks++;
    if (cap_addr[s] !== a[11:0]) begin failures++; $display("FAIL wr_slave_addr: got %h expected %h", cap_addr[s], a[11:0]); end
    checks++;
    if (cap_data[s] !== d) begin failures++; $display("FAIL wr_slave_data: got %h expected %h", cap_data[s], d); end
    checks++;
    if (s_vcnt[s] !== 20) begin failures++; $display("FAIL wr_valid_count: got %0d expected 20", s_vcnt[s]); end
    checks++;
    if (others !== 0) begin failures++; $display("FAIL wr_other_slaves: got %0d expected 0", others); end
    checks++;
    if (wr_seen[s] !== 1'b1) begin failures++; $display("FAIL wr_level: got %b expected 1", wr_seen[s]); end
    checks++;
    if (done_cnt[m] !== 1 || err_cnt[m] !== 0) begin
      failures++; $display("FAIL wr_done: got done=%0d err=%0d expected done=1 err=0", done_cnt[m], err_cnt[m]);
    end
    checks++;
    if (all_outs() !== 22'd0 || stray !== 0) begin
      failures++; $display("FAIL wr_idle_after: got outs=%h stray=%0d expected 0", all_outs(), stray);
    end
  endtask

  task automatic run_read(input int m, input logic [13:0] a, input logic [7:0] d, input bit gapless);
    int s; int n; int others;
    s = int'(a[13:12]);
    clear_obs();
    start_req(m, 1'b0, n);
    checks++;
    if (n !== 1) begin failures++; $display("FAIL rd_grant_latency: got %0d expected 1", n); end
    send_addr(m, a, gapless);
    wait_aout_end(s);
    for (int i = 7; i >= 0; i--) begin
      if (!gapless) repeat ($urandom_range(3, 0)) tick();
      sdin[s] = d[i];
      srdy[s] = 1'b1;
      tick();
      srdy[s] = 1'b0;
      sdin[s] = 1'b0;
    end
    wait_done(m, 4);
    req[m] = 1'b0;
    tick();
    tick();
    others = 0;
    for (int k = 0; k < 3; k++) if (k != s) others += s_vcnt[k];
    checks++;
    if (cap_addr[s] !== a[11:0]) begin failures++; $display("FAIL rd_slave_addr: got %h expected %h", cap_addr[s], a[11:0]); end
    checks++;
    if (rd_word[m] !== d || rd_cnt[m] !== 8) begin
      failures++; $display("FAIL rd_data: got %h (%0d bits) expected %h (8 bits)", rd_word[m], rd_cnt[m], d);
    end
    checks++;
    if (others !== 0 || s_vcnt[s] !== 12) begin
      failures++; $display("FAIL rd_slave_valid: got sel=%0d others=%0d expected 12 and 0", s_vcnt[s], others);
    end
    checks++;
    if (wr_seen[s] !== 1'b0) begin failures++; $display("FAIL rd_wr_level: got %b expected 0", wr_seen[s]); end
    checks++;
    if (done_cnt[m] !== 1 || err_cnt[m] !== 0) begin
      failures++; $display("FAIL rd_done: got done=%0d err=%0d expected done=1 err=0", done_cnt[m], err_cnt[m]);
    end
    checks++;
    if (all_outs() !== 22'd0 || stray !== 0) begin
      failures++; $display("FAIL rd_idle_after: got outs=%h stray=%0d expected 0", all_outs(), stray);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    zero_inputs();
    req = 2'b11;
    maval = 2'b11;
    srdy = 3'b111;
    tick();
    tick();
    checks++;
    if (all_outs() !== 22'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    zero_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (all_outs() !== 22'd0) begin failures++; $display("FAIL post_reset_idle: got %h expected 0", all_outs()); end
  endtask

  task automatic test_write();
    run_write(0, 14'h0123, 8'hA5, 1'b1);
    for (int t = 0; t < 3; t++) begin
      logic [1:0] sel; logic [11:0] loc;
      sel = 2'($urandom_range(2, 0));
      loc = 12'($urandom);
      run_write(int'($urandom_range(1, 0)), {sel, loc}, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_read();
    run_read(1, 14'h2040, 8'h3C, 1'b1);
    for (int t = 0; t < 3; t++) begin
      logic [1:0] sel; logic [11:0] loc;
      sel = 2'($urandom_range(2, 0));
      loc = 12'($urandom);
      run_read(int'($urandom_range(1, 0)), {sel, loc}, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_err_decode();
    int total;
    clear_obs();
    req[0] = 1'b1;
    wr[0] = 1'b1;
    tick();
    send_addr(0, 14'h3FFF, 1'b0);
    wait_done(0, 6);
    req[0] = 1'b0;
    tick();
    tick();
    total = s_vcnt[0] + s_vcnt[1] + s_vcnt[2];
    checks++;
    if (total !== 0 || wr_seen[0] || wr_seen[1] || wr_seen[2]) begin
      failures++; $display("FAIL err_slave_quiet: got %0d valids expected 0", total);
    end
    checks++;
    if (done_cnt[0] !== 1 || err_cnt[0] !== 1) begin
      failures++; $display("FAIL err_done: got done=%0d err=%0d expected 1 1", done_cnt[0], err_cnt[0]);
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    clear_obs();
    req = 2'b11;
    tick();
    checks++;
    if (avail !== 2'b01) begin failures++; $display("FAIL arb_first: got %b expected 01", avail); end
    send_addr(0, 14'h3FFF, 1'b1);
    wait_done(0, 6);
    for (int k = 0; k < 6; k++) begin
      if (avail[1]) break;
      tick();
    end
    checks++;
    if (avail !== 2'b10) begin failures++; $display("FAIL arb_second: got %b expected 10", avail); end
    send_addr(1, 14'h3FFF, 1'b1);
    wait_done(1, 6);
    req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (avail[0]) break;
      tick();
    end
    checks++;
    if (avail !== 2'b01) begin failures++; $display("FAIL arb_third: got %b expected 01", avail); end
    send_addr(0, 14'h3FFF, 1'b1);
    clear_obs();
    wait_done(0, 6);
    req = 2'b00;
    tick();
    tick();
    checks++;
    if (done_cnt[0] !== 1 || err_cnt[0] !== 1) begin
      failures++; $display("FAIL arb_done: got done=%0d err=%0d expected 1 1", done_cnt[0], err_cnt[0]);
    end
  endtask

  task automatic test_timeout();
    int n; int t0; logic [13:0] a;
    clear_obs();
    a = {2'b10, 12'($urandom)};
    start_req(0, 1'b0, n);
    send_addr(0, a, 1'b0);
    wait_aout_end(2);
    t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      if (done_cnt[0] > 0) break;
      tick();
    end
    checks++;
    if (done_cnt[0] !== 1 || err_cnt[0] !== 1) begin
      failures++; $display("FAIL tmo_done: got done=%0d err=%0d expected 1 1", done_cnt[0], err_cnt[0]);
    end
    checks++;
    if (done_cyc[0] - t0 < 250 || done_cyc[0] - t0 > 260) begin
      failures++; $display("FAIL tmo_latency: got %0d expected about 255", done_cyc[0] - t0);
    end
    checks++;
    if (svalid[2] !== 1'b0 || swr[2] !== 1'b0 || wr_seen[2] || s_vcnt[2] !== 12) begin
      failures++; $display("FAIL tmo_slave_lines: got valid=%b wr=%b count=%0d expected 0 0 12", svalid[2], swr[2], s_vcnt[2]);
    end
    req[0] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    clear_obs();
    req[0] = 1'b1;
    wr[0] = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      maddr[0] = 1'($urandom);
      maval[0] = 1'b1;
      tick();
    end
    maval[0] = 1'b0;
    maddr[0] = 1'b0;
    req[0] = 1'b0;
    tick();
    checks++;
    if (all_outs() !== 22'd0) begin failures++; $display("FAIL abort_outputs: got %h expected 0", all_outs()); end
    repeat (5) tick();
    checks++;
    if (done_cnt[0] !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt[0]); end
    req = 2'b11;
    tick();
    checks++;
    if (avail !== 2'b10) begin failures++; $display("FAIL abort_pointer: got %b expected 10", avail); end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    clear_obs();
    start_req(0, 1'b1, n);
    send_addr(0, {2'b01, 12'($urandom)}, 1'b1);
    wait_aout_end(1);
    for (int i = 0; i < 3; i++) begin
      mdata[0] = 1'b1;
      mval[0] = 1'b1;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 22'd0) begin failures++; $display("FAIL rst_async_outputs: got %h expected 0", all_outs()); end
    zero_inputs();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (all_outs() !== 22'd0 || done_cnt[0] !== 0) begin
      failures++; $display("FAIL rst_mid_idle: got outs=%h done=%0d expected 0 0", all_outs(), done_cnt[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    reset = 1'b1;
    zero_inputs();
    clear_obs();
    test_reset();
    test_write();
    test_read();
    test_err_decode();
    test_arbitration();
    test_timeout();
    test_abort();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
